data_path: RTL and testbench
============================

// Module: data_path
// PURPOSE
// - K&S processor datapath. It is the stage directly downstream of control_unit.
// - Holds PC, IR, a 4x16 register file, the ALU and the flags register.
// - Decodes IR into decoded_instruction and feeds it, plus the registered flags, back to control_unit.
// - Drives the address and write-data buses of the 32x16 program/data RAM.
// PARAMETERS
// - DATA_W  16  width of RAM words, registers and ALU.
// - ADDR_W  5   RAM address width; also the width of the PC and of the IR address field.
// PORTS
// - clk                  in   1       clock; all state updates on the rising edge.
// - rst_n                in   1       asynchronous, active-low reset.
// - branch               in   1       PC load source select: 1 = IR[4:0], 0 = PC+1.
// - pc_enable            in   1       PC update strobe.
// - ir_enable            in   1       IR load strobe; IR <= data_in.
// - write_reg_enable     in   1       register file write strobe.
// - addr_sel             in   1       ram_addr select: 0 = PC, 1 = IR[4:0].
// - c_sel                in   1       write-back bus select: 1 = ALU result, 0 = data_in.
// - operation            in   2       ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR.
// - flags_reg_enable     in   1       flags register update strobe.
// - decoded_instruction  out  enum    decoded_instruction_type, combinational from IR.
// - zero_op              out  1       registered flag: result == 0.
// - neg_op               out  1       registered flag: result[15].
// - unsigned_overflow    out  1       registered flag: carry out (ADD) or borrow (SUB).
// - signed_overflow      out  1       registered flag: two's-complement overflow.
// - ram_addr             out  ADDR_W  RAM address.
// - data_out             out  DATA_W  RAM write data.
// - data_in              in   DATA_W  RAM read data; asynchronous read, valid in the same cycle as ram_addr.
// BEHAVIOUR
// - Reset: PC=0, IR=0 (decodes as I_NOP), all registers R0..R3=0, all four flags=0.
//   Reset is honoured mid-instruction; no partial write survives it.
// - Opcode in IR[15:8]:
//   - 81 LOAD, 82 STORE, 91 MOVE.
//   - A1 ADD, A2 SUB, A3 AND, A4 OR.
//   - 01 BRANCH, 02 BZERO, 03 BNEG, 05 BOV, 06 BNOV, 0A BNNEG, 0B BNZERO.
//   - FF HALT.
//   - Any other opcode decodes to I_NOP.
// - Fields:
//   - LOAD/STORE: register in IR[6:5], address in IR[4:0].
//   - MOVE: destination in IR[3:2], source in IR[1:0].
//   - ALU ops: C in IR[5:4], A in IR[3:2], B in IR[1:0].
//   - Branches: target in IR[4:0].
// - Read port A address: IR[6:5] for STORE; IR[1:0] for MOVE; IR[3:2] otherwise.
// - Read port B address: always IR[1:0]. For MOVE, control_unit issues OR, so the result is src|src = src.
// - Write address: IR[6:5] for LOAD; IR[3:2] for MOVE; IR[5:4] for ALU ops.
// - Combinational paths, zero latency:
//   - data_out = port A.
//   - bus_c = c_sel ? alu : data_in.
//   - ram_addr = addr_sel ? IR[4:0] : PC.
// - PC update: when pc_enable=1, PC <= branch ? IR[4:0] : PC+1. The increment wraps 31 -> 0.
// - Register write: when write_reg_enable=1, reg[wr_addr] <= bus_c.
//   A read of the register being written in the same cycle returns the old value (no bypass).
// - ALU: DATA_W-bit, wrap-around arithmetic.
//   - ADD: unsigned_overflow = carry out of bit 15.
//   - SUB (A-B): unsigned_overflow = borrow, i.e. A < B unsigned.
//   - signed_overflow: operands have equal sign for ADD (opposite sign for SUB) and the result sign differs.
//   - AND/OR: both overflow flags = 0.
// - Flags: when flags_reg_enable=1, all four flags are loaded together from the current ALU result.
//   Otherwise they hold.
// - Simultaneous strobes: pc_enable, ir_enable, write_reg_enable and flags_reg_enable are independent and all take effect on the same edge.
//   Every input is sampled from pre-edge state. For example, IR and PC loading together use the old PC for ram_addr.
// STRUCTURE
// - k_and_s_pkg owns:
//   - decoded_instruction_type enum (I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT).
//   - Opcode localparams.
//   - ALU op encoding constants.
// - One sub-module: ks_reg_file.
//   - 4 x DATA_W registers, two combinational read ports, one synchronous write port, asynchronous reset to 0.
// - The decoder and ALU stay inline in data_path.
// TESTING
// - Reset: hold rst_n=0, then release -> PC=0, ram_addr=0, decoded_instruction=I_NOP, all flags 0.
// - Fetch: data_in=16'h8123, ir_enable=1 -> next cycle decoded_instruction=I_LOAD.
//   Then addr_sel=1 gives ram_addr=5'h03.
//   Then data_in=16'h00AA, c_sel=0, write_reg_enable=1 -> R1=16'h00AA.
// - ADD: R1=7FFF, R2=0001, IR=16'hA106 (C=R0, A=R1, B=R2), operation=00, c_sel=1, write and flags enabled
//   -> R0=8000, neg_op=1, signed_overflow=1, unsigned_overflow=0, zero_op=0.
// - SUB: R1=0003, R2=0003, IR=16'hA236, operation=01, c_sel=1, write and flags enabled
//   -> R3=0, zero_op=1, unsigned_overflow=0.
//   Repeat with R2=0004 -> R3=FFFF, unsigned_overflow=1, neg_op=1.
// - PC: PC=31, pc_enable=1, branch=0 -> PC=0.
//   Then IR=16'h0114, pc_enable=1, branch=1 -> PC=5'h14.
// - STORE/MOVE:
//   - IR=16'h8245 with R2=1234, addr_sel=1 -> ram_addr=05, data_out=1234.
//   - IR=16'h9106, operation=11, c_sel=1, write_reg_enable=1 -> R1 = R2.
//   - Opcode 16'h7700 -> decoded_instruction=I_NOP.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S processor: opcodes, ALU op codes,
// the decoded instruction enum and the flags payload.
package k_and_s_pkg;

    localparam int unsigned KS_DATA_W = 16;
    localparam int unsigned KS_ADDR_W = 5;
    localparam int unsigned REG_N     = 4;
    localparam int unsigned REG_AW    = 2;

    localparam logic [7:0] OPC_LOAD   = 8'h81;
    localparam logic [7:0] OPC_STORE  = 8'h82;
    localparam logic [7:0] OPC_MOVE   = 8'h91;
    localparam logic [7:0] OPC_ADD    = 8'hA1;
    localparam logic [7:0] OPC_SUB    = 8'hA2;
    localparam logic [7:0] OPC_AND    = 8'hA3;
    localparam logic [7:0] OPC_OR     = 8'hA4;
    localparam logic [7:0] OPC_BRANCH = 8'h01;
    localparam logic [7:0] OPC_BZERO  = 8'h02;
    localparam logic [7:0] OPC_BNEG   = 8'h03;
    localparam logic [7:0] OPC_BOV    = 8'h05;
    localparam logic [7:0] OPC_BNOV   = 8'h06;
    localparam logic [7:0] OPC_BNNEG  = 8'h0A;
    localparam logic [7:0] OPC_BNZERO = 8'h0B;
    localparam logic [7:0] OPC_HALT   = 8'hFF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO, I_HALT
    } decoded_instruction_type;

    typedef struct packed {
        logic zero;
        logic neg;
        logic uov;
        logic sov;
    } flags_t;

endpackage

// File: rtl/ks_reg_file.sv
// 4-entry register file: two combinational read ports, one synchronous write
// port; reads during a write return the pre-edge value.
module ks_reg_file
    import k_and_s_pkg::*;
#(
    parameter int unsigned DATA_W = KS_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_a_addr,
    input  logic [REG_AW-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_a_data,
    output logic [DATA_W-1:0] rd_b_data
);

    logic [DATA_W-1:0] regs_q [REG_N];
    logic [DATA_W-1:0] regs_d [REG_N];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_a_data = regs_q[rd_a_addr];
    assign rd_b_data = regs_q[rd_b_addr];

endmodule

// File: rtl/data_path.sv
// K&S processor datapath: PC, IR, register file, ALU and flags, with the
// instruction decoder feeding control_unit.
module data_path
    import k_and_s_pkg::*;
#(
    parameter int unsigned DATA_W = KS_DATA_W,
    parameter int unsigned ADDR_W = KS_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    write_reg_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    input  logic [DATA_W-1:0]       data_in
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    flags_t            flags_q, flags_d;

    logic [REG_AW-1:0] rd_a_addr, wr_addr;
    logic [DATA_W-1:0] a_val, b_val, alu_res, bus_c;
    logic [DATA_W:0]   sum_ext;
    logic              alu_uov, alu_sov;
    logic              unused_ir_bit;

    assign unused_ir_bit = ir_q[7];

    always_comb begin
        decoded_instruction = I_NOP;
        case (ir_q[15:8])
            OPC_LOAD:   decoded_instruction = I_LOAD;
            OPC_STORE:  decoded_instruction = I_STORE;
            OPC_MOVE:   decoded_instruction = I_MOVE;
            OPC_ADD:    decoded_instruction = I_ADD;
            OPC_SUB:    decoded_instruction = I_SUB;
            OPC_AND:    decoded_instruction = I_AND;
            OPC_OR:     decoded_instruction = I_OR;
            OPC_BRANCH: decoded_instruction = I_BRANCH;
            OPC_BZERO:  decoded_instruction = I_BZERO;
            OPC_BNEG:   decoded_instruction = I_BNEG;
            OPC_BOV:    decoded_instruction = I_BOV;
            OPC_BNOV:   decoded_instruction = I_BNOV;
            OPC_BNNEG:  decoded_instruction = I_BNNEG;
            OPC_BNZERO: decoded_instruction = I_BNZERO;
            OPC_HALT:   decoded_instruction = I_HALT;
            default:    decoded_instruction = I_NOP;
        endcase
    end

    // Register addressing depends on the instruction format.
    always_comb begin
        rd_a_addr = ir_q[3:2];
        wr_addr   = ir_q[5:4];
        case (decoded_instruction)
            I_LOAD:  wr_addr   = ir_q[6:5];
            I_STORE: rd_a_addr = ir_q[6:5];
            I_MOVE: begin
                rd_a_addr = ir_q[1:0];
                wr_addr   = ir_q[3:2];
            end
            default: ;
        endcase
    end

    ks_reg_file #(.DATA_W(DATA_W)) u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (write_reg_enable),
        .wr_addr   (wr_addr),
        .wr_data   (bus_c),
        .rd_a_addr (rd_a_addr),
        .rd_b_addr (ir_q[1:0]),
        .rd_a_data (a_val),
        .rd_b_data (b_val)
    );

    // ALU with carry/borrow and two's-complement overflow detection.
    always_comb begin
        sum_ext = '0;
        alu_res = '0;
        alu_uov = 1'b0;
        alu_sov = 1'b0;
        case (operation)
            ALU_ADD: begin
                sum_ext = {1'b0, a_val} + {1'b0, b_val};
                alu_res = sum_ext[DATA_W-1:0];
                alu_uov = sum_ext[DATA_W];
                alu_sov = (a_val[DATA_W-1] == b_val[DATA_W-1])
                          && (alu_res[DATA_W-1] != a_val[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_res = a_val - b_val;
                alu_uov = a_val < b_val;
                alu_sov = (a_val[DATA_W-1] != b_val[DATA_W-1])
                          && (alu_res[DATA_W-1] != a_val[DATA_W-1]);
            end
            ALU_AND: alu_res = a_val & b_val;
            default: alu_res = a_val | b_val;
        endcase
    end

    assign bus_c    = c_sel ? alu_res : data_in;
    assign data_out = a_val;
    assign ram_addr = addr_sel ? ir_q[ADDR_W-1:0] : pc_q;

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        if (pc_enable) begin
            pc_d = branch ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
        end
        if (ir_enable) begin
            ir_d = data_in;
        end
        if (flags_reg_enable) begin
            flags_d.zero = (alu_res == '0);
            flags_d.neg  = alu_res[DATA_W-1];
            flags_d.uov  = alu_uov;
            flags_d.sov  = alu_sov;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    assign zero_op           = flags_q.zero;
    assign neg_op            = flags_q.neg;
    assign unsigned_overflow = flags_q.uov;
    assign signed_overflow   = flags_q.sov;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios plus randomized
// strobes checked against an arithmetic reference model.
module tb_data_path;
    import k_and_s_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch, pc_enable, ir_enable, write_reg_enable;
    logic        addr_sel, c_sel, flags_reg_enable;
    logic [1:0]  operation;
    logic [15:0] data_in;
    decoded_instruction_type decoded_instruction;
    logic        zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic [4:0]  ram_addr;
    logic [15:0] data_out;

    always #5 clk = ~clk;

    data_path dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .write_reg_enable    (write_reg_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .flags_reg_enable    (flags_reg_enable),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .ram_addr            (ram_addr),
        .data_out            (data_out),
        .data_in             (data_in)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] m_r [4];
    logic [15:0] m_ir;
    int          m_pc;
    logic        m_z, m_n, m_u, m_s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic decoded_instruction_type ref_decode(input logic [15:0] ir);
        case (ir[15:8])
            8'h81: return I_LOAD;   8'h82: return I_STORE;  8'h91: return I_MOVE;
            8'hA1: return I_ADD;    8'hA2: return I_SUB;    8'hA3: return I_AND;
            8'hA4: return I_OR;     8'h01: return I_BRANCH; 8'h02: return I_BZERO;
            8'h03: return I_BNEG;   8'h05: return I_BOV;    8'h06: return I_BNOV;
            8'h0A: return I_BNNEG;  8'h0B: return I_BNZERO; 8'hFF: return I_HALT;
            default: return I_NOP;
        endcase
    endfunction

    function automatic int ref_rd_a(input logic [15:0] ir);
        if (ir[15:8] == 8'h82) return int'(ir[6:5]);
        if (ir[15:8] == 8'h91) return int'(ir[1:0]);
        return int'(ir[3:2]);
    endfunction

    function automatic int ref_wr(input logic [15:0] ir);
        if (ir[15:8] == 8'h81) return int'(ir[6:5]);
        if (ir[15:8] == 8'h91) return int'(ir[3:2]);
        return int'(ir[5:4]);
    endfunction

    function automatic bit writable(input logic [15:0] ir);
        return ir[15:8] inside {8'h81, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    endfunction

    // Integer arithmetic: flags come from the range of the exact result.
    task automatic ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic z, output logic n,
                           output logic u, output logic s);
        int ua, ub, sa, sb, full, sfull;
        ua = int'(a);  ub = int'(b);
        sa = int'($signed(a));  sb = int'($signed(b));
        u = 1'b0;  s = 1'b0;
        case (op)
            2'd0: begin full = ua + ub; sfull = sa + sb; u = full > 65535; s = sfull > 32767 || sfull < -32768; end
            2'd1: begin full = ua - ub; sfull = sa - sb; u = ua < ub;      s = sfull > 32767 || sfull < -32768; end
            2'd2: full = int'(a & b);
            default: full = int'(a | b);
        endcase
        r = full[15:0];
        z = (r == 16'h0);
        n = r[15];
    endtask

    task automatic model_reset();
        m_pc = 0;  m_ir = '0;
        m_z = 0;  m_n = 0;  m_u = 0;  m_s = 0;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
    endtask

    task automatic check_outputs();
        chk("ram_addr", 32'(ram_addr), addr_sel ? 32'(m_ir[4:0]) : 32'(m_pc));
        chk("data_out", 32'(data_out), 32'(m_r[ref_rd_a(m_ir)]));
        chk("decode",   32'(decoded_instruction), 32'(ref_decode(m_ir)));
        chk("flags",    {28'h0, zero_op, neg_op, unsigned_overflow, signed_overflow},
                        {28'h0, m_z, m_n, m_u, m_s});
    endtask

    // Check pre-edge outputs, clock once, advance the model from pre-edge state.
    task automatic cycle();
        logic [15:0] res;
        logic        z, n, u, s;
        int          npc;
        #1;
        check_outputs();
        ref_alu(operation, m_r[ref_rd_a(m_ir)], m_r[int'(m_ir[1:0])], res, z, n, u, s);
        npc = branch ? int'(m_ir[4:0]) : (m_pc + 1) % 32;
        @(posedge clk);
        if (write_reg_enable) m_r[ref_wr(m_ir)] = c_sel ? res : data_in;
        if (flags_reg_enable) begin m_z = z; m_n = n; m_u = u; m_s = s; end
        if (pc_enable) m_pc = npc;
        if (ir_enable) m_ir = data_in;
        @(negedge clk);
    endtask

    task automatic idle();
        branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
        addr_sel = 0; c_sel = 0; operation = 2'd0; flags_reg_enable = 0; data_in = '0;
    endtask

    task automatic load_ir(input logic [15:0] v);
        idle(); data_in = v; ir_enable = 1; cycle(); idle();
    endtask

    task automatic set_reg(input int r, input logic [15:0] v);
        load_ir(16'h8100 | (16'(r) << 5));
        data_in = v; write_reg_enable = 1; cycle(); idle();
    endtask

    task automatic read_reg(input string tag, input int r, input logic [15:0] exp);
        load_ir(16'h8200 | (16'(r) << 5));
        #1 chk(tag, 32'(data_out), 32'(exp));
    endtask

    task automatic alu_op(input logic [15:0] ir, input logic [1:0] op);
        load_ir(ir);
        operation = op; c_sel = 1; write_reg_enable = 1; flags_reg_enable = 1;
        cycle(); idle();
    endtask

    logic [7:0] opc [16] = '{8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h01,
                             8'h02, 8'h03, 8'h05, 8'h06, 8'h0A, 8'h0B, 8'hFF, 8'h77};

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_outputs();
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_decode", 32'(decoded_instruction), 32'(I_NOP));
        rst_n = 1;
        @(negedge clk);

        load_ir(16'h8123);
        chk("fetch_decode", 32'(decoded_instruction), 32'(I_LOAD));
        addr_sel = 1;
        #1 chk("fetch_addr", 32'(ram_addr), 32'h03);
        data_in = 16'h00AA; write_reg_enable = 1; cycle(); idle();
        read_reg("load_r1", 1, 16'h00AA);

        set_reg(1, 16'h7FFF); set_reg(2, 16'h0001);
        alu_op(16'hA106, 2'd0);
        chk("add_flags", {28'h0, zero_op, neg_op, unsigned_overflow, signed_overflow}, 32'b0101);
        read_reg("add_r0", 0, 16'h8000);

        set_reg(1, 16'h0003); set_reg(2, 16'h0003);
        alu_op(16'hA236, 2'd1);
        chk("sub_eq_flags", {28'h0, zero_op, neg_op, unsigned_overflow, signed_overflow}, 32'b1000);
        read_reg("sub_eq_r3", 3, 16'h0000);
        set_reg(2, 16'h0004);
        alu_op(16'hA236, 2'd1);
        chk("sub_lt_flags", {28'h0, zero_op, neg_op, unsigned_overflow, signed_overflow}, 32'b0110);
        read_reg("sub_lt_r3", 3, 16'hFFFF);

        load_ir(16'h011F);
        pc_enable = 1; branch = 1; cycle(); idle();
        #1 chk("pc_31", 32'(ram_addr), 32'd31);
        pc_enable = 1; cycle(); idle();
        #1 chk("pc_wrap", 32'(ram_addr), 32'd0);
        load_ir(16'h0114);
        pc_enable = 1; branch = 1; cycle(); idle();
        #1 chk("pc_branch", 32'(ram_addr), 32'h14);

        set_reg(2, 16'h1234);
        load_ir(16'h8245);
        addr_sel = 1;
        #1 chk("store_addr", 32'(ram_addr), 32'h05);
        chk("store_data", 32'(data_out), 32'h1234);
        load_ir(16'h9106);
        operation = 2'd3; c_sel = 1; write_reg_enable = 1; cycle(); idle();
        read_reg("move_r1", 1, 16'h1234);
        load_ir(16'h7700);
        chk("nop_decode", 32'(decoded_instruction), 32'(I_NOP));

        for (int it = 0; it < 600; it++) begin
            if (it % 50 == 49) begin
                rst_n = 0;
                #1 model_reset();
                check_outputs();
                rst_n = 1;
            end
            branch           = 1'($urandom);
            pc_enable        = 1'($urandom);
            ir_enable        = 1'($urandom);
            addr_sel         = 1'($urandom);
            c_sel            = 1'($urandom);
            operation        = 2'($urandom);
            flags_reg_enable = 1'($urandom);
            write_reg_enable = writable(m_ir) && ($urandom_range(0, 2) != 0);
            data_in = ($urandom_range(0, 1) != 0) ? {opc[$urandom_range(0, 15)], 8'($urandom)}
                                                  : 16'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
